// File: rtl/generation_scheduler_pkg.sv
// rtl/generation_scheduler_pkg.sv - shared sizes, FSM state type and seed LFSR step for the generation scheduler
package generation_scheduler_pkg;

    localparam int GENE_W   = 150;
    localparam int FAMILY_N = 5;
    localparam int COST_W   = 16;
    localparam int GEN_W    = 16;
    localparam int STALL_W  = 8;
    localparam int IDX_W    = 3;

    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_FAM,
        S_EVAL,
        S_SELECT,
        S_DONE
    } sched_state_t;

    // Bit 31 is set whenever feedback fires, so a nonzero state never steps to zero
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/generation_scheduler_if.sv
// rtl/generation_scheduler_if.sv - family generator and fitness evaluator handshake bundle
interface generation_scheduler_if;
    import generation_scheduler_pkg::*;

    logic                         iter_start;
    logic [31:0]                  iter_seed;
    logic [GENE_W-1:0]            iter_parent;
    logic                         iter_done;
    logic [GENE_W*FAMILY_N-1:0]   iter_family;
    logic                         eval_req;
    logic [GENE_W-1:0]            eval_genome;
    logic                         eval_ack;
    logic [COST_W-1:0]            eval_cost;

    modport master (
        output iter_start, iter_seed, iter_parent, eval_req, eval_genome,
        input  iter_done, iter_family, eval_ack, eval_cost
    );

    modport slave (
        input  iter_start, iter_seed, iter_parent, eval_req, eval_genome,
        output iter_done, iter_family, eval_ack, eval_cost
    );

endinterface

// File: rtl/generation_scheduler_seed_lfsr.sv
// rtl/generation_scheduler_seed_lfsr.sv - 32-bit PRG seed register with zero-seed substitution
module generation_scheduler_seed_lfsr
    import generation_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_step,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    // Load wins over step; a zero seed would lock the LFSR so it becomes 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= (i_seed == 32'h0) ? 32'h1 : i_seed;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/generation_scheduler.sv
// rtl/generation_scheduler.sv - GA run sequencer around family generator and shared evaluator (optional STALL_EXIT_EN)
module generation_scheduler
    import generation_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_go,
    input  logic [GEN_W-1:0]        i_cfg_gens,
    input  logic [31:0]             i_cfg_seed,
    input  logic [GENE_W-1:0]       i_init_genome,
`ifdef STALL_EXIT_EN
    input  logic [STALL_W-1:0]      i_cfg_stall,
`endif
    generation_scheduler_if.master  sched,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [GENE_W-1:0]       o_best_genome,
    output logic [COST_W-1:0]       o_best_cost,
    output logic [GEN_W-1:0]        o_gen_count
);

    sched_state_t                 r_state, w_next;
    logic [GEN_W-1:0]             r_gens;
    logic [GENE_W-1:0]            r_parent;
    logic [GENE_W*FAMILY_N-1:0]   r_family;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_gap;
    logic [GENE_W-1:0]            r_best_genome;
    logic [COST_W-1:0]            r_best_cost;
    logic [GEN_W-1:0]             r_gen_count;

    logic [GENE_W-1:0]            w_slot;
    logic                         w_ack;
    logic                         w_last_slot;
    logic                         w_last_gen;
    logic [GEN_W-1:0]             w_gen_inc;
    logic                         w_stall_exit;
    logic [31:0]                  w_seed;

    assign w_slot      = r_family[int'(r_idx)*GENE_W +: GENE_W];
    assign w_ack       = (r_state == S_EVAL) && !r_gap && sched.eval_ack;
    assign w_last_slot = (r_idx == IDX_W'(FAMILY_N - 1));
    assign w_last_gen  = (({1'b0, r_gen_count} + 1'b1) == {1'b0, r_gens});
    assign w_gen_inc   = (&r_gen_count) ? r_gen_count : r_gen_count + 1'b1;

`ifdef STALL_EXIT_EN
    logic [STALL_W-1:0]           r_cfg_stall;
    logic [STALL_W-1:0]           r_stall_cnt;
    logic                         r_improved;
    logic [STALL_W-1:0]           w_stall_next;

    assign w_stall_next = r_improved ? '0 :
                          ((&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + 1'b1);
    assign w_stall_exit = (r_cfg_stall != '0) && (w_stall_next == r_cfg_stall);

    // Count generations in which no non-parent slot beat the parent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_stall <= '0;
            r_stall_cnt <= '0;
            r_improved  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_go) begin
                r_cfg_stall <= i_cfg_stall;
                r_stall_cnt <= '0;
            end
            if (r_state == S_WAIT_FAM && sched.iter_done) begin
                r_improved <= 1'b0;
            end
            if (w_ack && sched.eval_cost < r_best_cost && r_idx != '0) begin
                r_improved <= 1'b1;
            end
            if (r_state == S_SELECT) begin
                r_stall_cnt <= w_stall_next;
            end
        end
    end
`else
    assign w_stall_exit = 1'b0;
`endif

    generation_scheduler_seed_lfsr u_seed (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  ((r_state == S_IDLE) && i_go),
        .i_seed  (i_cfg_seed),
        .i_step  (r_state == S_SELECT),
        .o_state (w_seed)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_go) w_next = S_LAUNCH;
            S_LAUNCH:   w_next = S_WAIT_FAM;
            S_WAIT_FAM: if (sched.iter_done) w_next = S_EVAL;
            S_EVAL:     if (w_ack && w_last_slot) w_next = S_SELECT;
            S_SELECT:   w_next = (w_last_gen || w_stall_exit) ? S_DONE : S_LAUNCH;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Run datapath: config latch, family capture, strict-min tracking, parent hand-over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gens        <= '0;
            r_parent      <= '0;
            r_family      <= '0;
            r_idx         <= '0;
            r_gap         <= 1'b0;
            r_best_genome <= '0;
            r_best_cost   <= '0;
            r_gen_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_go) begin
                    r_gens      <= (i_cfg_gens == '0) ? GEN_W'(1) : i_cfg_gens;
                    r_parent    <= i_init_genome;
                    r_gen_count <= '0;
                end
                S_WAIT_FAM: if (sched.iter_done) begin
                    r_family      <= sched.iter_family;
                    r_idx         <= '0;
                    r_gap         <= 1'b0;
                    r_best_cost   <= '1;
                    r_best_genome <= sched.iter_family[GENE_W-1:0];
                end
                S_EVAL: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (w_ack) begin
                        // Strict compare: ties keep the lower slot, so the parent survives
                        if (sched.eval_cost < r_best_cost) begin
                            r_best_cost   <= sched.eval_cost;
                            r_best_genome <= w_slot;
                        end
                        if (!w_last_slot) begin
                            r_idx <= r_idx + 1'b1;
                            r_gap <= 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    r_parent    <= r_best_genome;
                    r_gen_count <= w_gen_inc;
                end
                default: ;
            endcase
        end
    end

    assign sched.iter_start  = (r_state == S_LAUNCH);
    assign sched.iter_seed   = w_seed;
    assign sched.iter_parent = r_parent;
    assign sched.eval_req    = (r_state == S_EVAL) && !r_gap;
    assign sched.eval_genome = w_slot;

    assign o_busy        = (r_state == S_LAUNCH) || (r_state == S_WAIT_FAM) ||
                           (r_state == S_EVAL)   || (r_state == S_SELECT);
    assign o_done        = (r_state == S_DONE);
    assign o_best_genome = r_best_genome;
    assign o_best_cost   = r_best_cost;
    assign o_gen_count   = r_gen_count;

endmodule

// File: tb/tb_generation_scheduler.sv
// tb/tb_generation_scheduler.sv - scoreboard bench for generation_scheduler
module tb_generation_scheduler;
    import generation_scheduler_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  go;
    logic [GEN_W-1:0]      cfg_gens;
    logic [31:0]           cfg_seed;
    logic [GENE_W-1:0]     init_genome;
`ifdef STALL_EXIT_EN
    logic [STALL_W-1:0]    cfg_stall;
`endif
    logic                  busy;
    logic                  done;
    logic [GENE_W-1:0]     best_genome;
    logic [COST_W-1:0]     best_cost;
    logic [GEN_W-1:0]      gen_count;

    generation_scheduler_if ifc();

    generation_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_go          (go),
        .i_cfg_gens    (cfg_gens),
        .i_cfg_seed    (cfg_seed),
        .i_init_genome (init_genome),
`ifdef STALL_EXIT_EN
        .i_cfg_stall   (cfg_stall),
`endif
        .sched         (ifc),
        .o_busy        (busy),
        .o_done        (done),
        .o_best_genome (best_genome),
        .o_best_cost   (best_cost),
        .o_gen_count   (gen_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       seed;
        logic [GENE_W-1:0] parent;
    } start_t;

    typedef struct packed {
        logic [GENE_W-1:0] genome;
        logic [COST_W-1:0] cost;
        logic [GEN_W-1:0]  gens;
    } done_t;

    start_t            q_start[$];
    logic [GENE_W-1:0] q_eval[$];
    done_t             q_done[$];
    logic [COST_W-1:0] cost_q[$];
    logic [COST_W-1:0] tcost [0:63];

    int n_vec    = 0;
    int n_err    = 0;
    int gen_idx  = 0;
    int done_cnt = 0;
    int wait_cnt = 0;
    bit rand_delay = 1'b0;

    function automatic logic [GENE_W-1:0] cand(input int g, input int k);
        return {8'(k), 110'h0, 16'hC0DE, 8'(g), 8'(k)};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic void chk(input string name, input logic [GENE_W-1:0] act, input logic [GENE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event want none", name);
    endfunction

    // Family generator model: slot 0 echoes the parent, other slots are tagged by generation/slot
    initial begin
        ifc.iter_done   = 1'b0;
        ifc.iter_family = '0;
        forever begin
            @(posedge clk); #1;
            if (ifc.iter_start) begin
                repeat (2) @(posedge clk);
                #1;
                for (int k = 0; k < FAMILY_N; k++)
                    ifc.iter_family[k*GENE_W +: GENE_W] = (k == 0) ? ifc.iter_parent : cand(gen_idx, k);
                ifc.iter_done = 1'b1;
                @(posedge clk); #1;
                ifc.iter_done   = 1'b0;
                ifc.iter_family = '1;
                gen_idx++;
            end
        end
    end

    // Evaluator model: one-cycle ack carrying the next queued cost, optional random delay
    initial begin
        ifc.eval_ack  = 1'b0;
        ifc.eval_cost = '0;
        forever begin
            @(posedge clk); #1;
            if (ifc.eval_ack) begin
                ifc.eval_ack = 1'b0;
            end else if (ifc.eval_req) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    ifc.eval_ack  = 1'b1;
                    ifc.eval_cost = (cost_q.size() > 0) ? cost_q.pop_front() : '1;
                    wait_cnt      = rand_delay ? int'($urandom_range(0, 7)) : 0;
                end
            end
        end
    end

    // Monitor: pop expectations whenever the DUT presents iter_start, a new eval_req, or done
    logic              req_d = 1'b0;
    logic [GENE_W-1:0] held;
    start_t            ms;
    done_t             md;
    always @(negedge clk) begin
        if (!rst_n) begin
            req_d = 1'b0;
        end else begin
            if (ifc.iter_start) begin
                if (q_start.size() == 0) unexpected("iter_start");
                else begin
                    ms = q_start.pop_front();
                    chk("iter_seed", GENE_W'(ifc.iter_seed), GENE_W'(ms.seed));
                    chk("iter_parent", ifc.iter_parent, ms.parent);
                end
            end
            if (ifc.eval_req) begin
                if (!req_d) begin
                    if (q_eval.size() == 0) unexpected("eval_req");
                    else begin
                        held = q_eval.pop_front();
                        chk("eval_genome", ifc.eval_genome, held);
                    end
                end else begin
                    chk("eval_genome_stable", ifc.eval_genome, held);
                end
            end
            req_d = ifc.eval_req;
            if (done) begin
                done_cnt++;
                if (q_done.size() == 0) unexpected("done");
                else begin
                    md = q_done.pop_front();
                    chk("best_genome", best_genome, md.genome);
                    chk("best_cost", GENE_W'(best_cost), GENE_W'(md.cost));
                    chk("gen_count", GENE_W'(gen_count), GENE_W'(md.gens));
                end
            end
        end
    end

    task automatic start_test(input logic [GEN_W-1:0] gens, input logic [31:0] seed,
                              input logic [GENE_W-1:0] init, input int nexp, input int stall);
        logic [GENE_W-1:0] par, bg, g;
        logic [COST_W-1:0] bc, c;
        logic [31:0]       s;
        start_t            st;
        done_t             dn;
        par = init;
        s   = (seed == 32'h0) ? 32'h1 : seed;
        bc  = '1;
        for (int gi = 0; gi < nexp; gi++) begin
            st.seed   = s;
            st.parent = par;
            q_start.push_back(st);
            bc = '1;
            bg = par;
            for (int k = 0; k < FAMILY_N; k++) begin
                g = (k == 0) ? par : cand(gi, k);
                c = tcost[gi*FAMILY_N + k];
                q_eval.push_back(g);
                cost_q.push_back(c);
                if (c < bc) begin
                    bc = c;
                    bg = g;
                end
            end
            par = bg;
            s   = lfsr_step(s);
        end
        dn.genome = par;
        dn.cost   = bc;
        dn.gens   = GEN_W'(nexp);
        q_done.push_back(dn);
        gen_idx  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        cfg_gens    = gens;
        cfg_seed    = seed;
        init_genome = init;
`ifdef STALL_EXIT_EN
        cfg_stall   = STALL_W'(stall);
`else
        if (stall != 0) $display("note: stall ignored in this build");
`endif
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk("busy_after_go", GENE_W'(busy), GENE_W'(1));
        chk("iter_start_latency", GENE_W'(ifc.iter_start), GENE_W'(1));
    endtask

    task automatic finish_test(input bit extra_go);
        int cyc;
        cyc = 0;
        if (extra_go) begin
            repeat (6) @(posedge clk);
            #1;
            cfg_gens    = GEN_W'(1);
            init_genome = '1;
            go          = 1'b1;
            @(posedge clk); #1;
            go          = 1'b0;
        end
        while (!done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) unexpected("done_timeout");
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", GENE_W'(done_cnt), GENE_W'(1));
        chk("busy_after_done", GENE_W'(busy), GENE_W'(0));
        chk("left_evals", GENE_W'(q_eval.size()), GENE_W'(0));
        chk("left_starts", GENE_W'(q_start.size()), GENE_W'(0));
    endtask

    task automatic set_costs(input int base, input logic [COST_W-1:0] c0, input logic [COST_W-1:0] c1,
                             input logic [COST_W-1:0] c2, input logic [COST_W-1:0] c3, input logic [COST_W-1:0] c4);
        tcost[base*FAMILY_N + 0] = c0;
        tcost[base*FAMILY_N + 1] = c1;
        tcost[base*FAMILY_N + 2] = c2;
        tcost[base*FAMILY_N + 3] = c3;
        tcost[base*FAMILY_N + 4] = c4;
    endtask

    localparam logic [GENE_W-1:0] INIT_A = {22'h2A_5A5A, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};

    initial begin
        int cyc;
        rst_n = 1'b0;
        go = 1'b0;
        cfg_gens = '0;
        cfg_seed = '0;
        init_genome = '0;
`ifdef STALL_EXIT_EN
        cfg_stall = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", GENE_W'(busy), GENE_W'(0));
        chk("rst_done", GENE_W'(done), GENE_W'(0));
        chk("rst_best_genome", best_genome, '0);
        chk("rst_best_cost", GENE_W'(best_cost), GENE_W'(0));
        chk("rst_gen_count", GENE_W'(gen_count), GENE_W'(0));
        chk("rst_iter_seed", GENE_W'(ifc.iter_seed), GENE_W'(0));
        chk("rst_eval_req", GENE_W'(ifc.eval_req), GENE_W'(0));
        rst_n = 1'b1;

        // T1: single generation, slot 1 wins the 40/40 tie against slot 3
        set_costs(0, 16'd50, 16'd40, 16'd60, 16'd40, 16'd70);
        start_test(16'd1, 32'h1, INIT_A, 1, 0);
        finish_test(1'b0);
        chk("t1_best_slot1", best_genome, cand(0, 1));
        chk("t1_best_cost", GENE_W'(best_cost), GENE_W'(16'd40));

        // T2: equal costs keep the parent every generation
        set_costs(0, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100);
        set_costs(1, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100);
        start_test(16'd2, 32'hDEAD_BEEF, INIT_A, 2, 0);
        finish_test(1'b0);
        chk("t2_parent_kept", best_genome, INIT_A);

        // gens=0 runs once; all-ones costs never displace the parent
        set_costs(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        start_test(16'd0, 32'h1234, ~INIT_A, 1, 0);
        finish_test(1'b0);
        chk("t2b_parent_kept", best_genome, ~INIT_A);
        chk("t2b_cost_ones", GENE_W'(best_cost), GENE_W'(16'hFFFF));

        // T3: zero seed -> 1, 80200003, C0300002 over three generations
        set_costs(0, 16'd30, 16'd20, 16'd25, 16'd20, 16'd40);
        set_costs(1, 16'd20, 16'd20, 16'd5, 16'd9, 16'd5);
        set_costs(2, 16'd5, 16'd6, 16'd7, 16'd8, 16'd4);
        start_test(16'd3, 32'h0, INIT_A, 3, 0);
        finish_test(1'b0);
        chk("t3_best_cost", GENE_W'(best_cost), GENE_W'(16'd4));

        // T4: random ack delays plus a go while busy
        rand_delay = 1'b1;
        set_costs(0, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5);
        set_costs(1, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5);
        set_costs(2, 16'd5, 16'd1, 16'd2, 16'd3, 16'd0);
        set_costs(3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        start_test(16'd4, 32'hCAFE_0001, INIT_A, 4, 0);
        finish_test(1'b1);
        rand_delay = 1'b0;
        wait_cnt = 0;

        // T5: abort during generation 2, then a fresh run
        set_costs(0, 16'd10, 16'd20, 16'd30, 16'd40, 16'd1);
        set_costs(1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        set_costs(2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        start_test(16'd3, 32'h5, INIT_A, 3, 0);
        cyc = 0;
        while (!(gen_idx == 2 && ifc.eval_req) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!(gen_idx == 2 && ifc.eval_req)) unexpected("abort_point_timeout");
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", GENE_W'(busy), GENE_W'(0));
        chk("abort_eval_req", GENE_W'(ifc.eval_req), GENE_W'(0));
        chk("abort_iter_seed", GENE_W'(ifc.iter_seed), GENE_W'(0));
        chk("abort_best_cost", GENE_W'(best_cost), GENE_W'(0));
        chk("abort_gen_count", GENE_W'(gen_count), GENE_W'(0));
        chk("abort_parent", ifc.iter_parent, '0);
        repeat (2) @(posedge clk);
        #1;
        q_start.delete();
        q_eval.delete();
        q_done.delete();
        cost_q.delete();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", GENE_W'(done_cnt), GENE_W'(0));
        start_test(16'd2, 32'h5, INIT_A, 2, 0);
        finish_test(1'b0);
        chk("t5_best", best_genome, cand(0, 4));

`ifdef STALL_EXIT_EN
        // T6: improvement only in gen 1, stall limit 2 ends the run at gen_count 3
        set_costs(0, 16'd100, 16'd50, 16'd60, 16'd70, 16'd80);
        set_costs(1, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50);
        set_costs(2, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50);
        start_test(16'd10, 32'h7, INIT_A, 3, 2);
        finish_test(1'b0);
        chk("t6_gen_count", GENE_W'(gen_count), GENE_W'(3));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
